// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: write port, two read ports, scoreboard issue,
// sequential-clear control and a debug read port.
interface regfile_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] raddr_a;
   logic [ADDR_W-1:0] raddr_b;
   logic [DATA_W-1:0] rdata_a;
   logic [DATA_W-1:0] rdata_b;
   logic              busy_a;
   logic              busy_b;
   logic              issue_en;
   logic [ADDR_W-1:0] issue_addr;
   logic              clr_req;
   logic              clr_busy;
   logic [ADDR_W-1:0] debug_addr;
   logic [DATA_W-1:0] debug_data;

   modport master (
      output we, waddr, wdata, raddr_a, raddr_b, issue_en, issue_addr,
             clr_req, debug_addr,
      input  rdata_a, rdata_b, busy_a, busy_b, clr_busy, debug_data
   );

   modport slave (
      input  we, waddr, wdata, raddr_a, raddr_b, issue_en, issue_addr,
             clr_req, debug_addr,
      output rdata_a, rdata_b, busy_a, busy_b, clr_busy, debug_data
   );
endinterface

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard, optional write-to-read
// forwarding and a one-register-per-cycle sequential clear.
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   regfile_sb_if.slave bus
);
   localparam int                DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PTR_LAST  = '1;

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy_q;

   logic idle, wr_ok, iss_ok, fwd_a, fwd_b;

   // Address 0 is hardwired: nothing may write or issue it.
   assign idle   = (state_q == IDLE);
   assign wr_ok  = idle && bus.we && (bus.waddr != '0);
   assign iss_ok = idle && bus.issue_en && (bus.issue_addr != '0);
   assign fwd_a  = (BYPASS != 0) && wr_ok && (bus.waddr == bus.raddr_a);
   assign fwd_b  = (BYPASS != 0) && wr_ok && (bus.waddr == bus.raddr_b);

   assign bus.rdata_a    = (bus.raddr_a == '0) ? '0 : (fwd_a ? bus.wdata : mem[bus.raddr_a]);
   assign bus.rdata_b    = (bus.raddr_b == '0) ? '0 : (fwd_b ? bus.wdata : mem[bus.raddr_b]);
   assign bus.busy_a     = (bus.raddr_a != '0) && !fwd_a && busy_q[bus.raddr_a];
   assign bus.busy_b     = (bus.raddr_b != '0) && !fwd_b && busy_q[bus.raddr_b];
   assign bus.debug_data = (bus.debug_addr == '0) ? '0 : mem[bus.debug_addr];
   assign bus.clr_busy   = (state_q == CLEAR);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (bus.clr_req) begin
               state_d = CLEAR;
               ptr_d   = PTR_FIRST;
            end
         end
         CLEAR: begin
            if (ptr_q == PTR_LAST) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
      endcase
   end

   // Issue is applied after the write so a same-cycle issue leaves busy set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         busy_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i[ADDR_W-1:0]] <= '0;
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         if (idle) begin
            if (wr_ok) begin
               mem[bus.waddr]    <= bus.wdata;
               busy_q[bus.waddr] <= 1'b0;
            end
            if (iss_ok) begin
               busy_q[bus.issue_addr] <= 1'b1;
            end
         end else begin
            mem[ptr_q]    <= '0;
            busy_q[ptr_q] <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table through a scoreboard queue,
// then hand-written clear, bypass-off and reset-during-clear sequences.
module tb_regfile_sb;
   localparam int DW = 32;
   localparam int AW = 5;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
   regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );
   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .bus(bus0)
   );

   // The no-bypass instance sees exactly the same stimulus.
   assign bus0.we         = bus1.we;
   assign bus0.waddr      = bus1.waddr;
   assign bus0.wdata      = bus1.wdata;
   assign bus0.raddr_a    = bus1.raddr_a;
   assign bus0.raddr_b    = bus1.raddr_b;
   assign bus0.issue_en   = bus1.issue_en;
   assign bus0.issue_addr = bus1.issue_addr;
   assign bus0.clr_req    = bus1.clr_req;
   assign bus0.debug_addr = bus1.debug_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      logic          iss;
      logic [AW-1:0] iaddr;
      logic [AW-1:0] ra;
      logic [AW-1:0] rb;
      logic [AW-1:0] dbg;
      logic [DW-1:0] e_ra;
      logic [DW-1:0] e_rb;
      logic          e_ba;
      logic          e_bb;
      logic [DW-1:0] e_dbg;
   } vec_t;

   typedef struct {
      logic [DW-1:0] ra;
      logic [DW-1:0] rb;
      logic          ba;
      logic          bb;
      logic [DW-1:0] dbg;
   } exp_t;

   vec_t vt [15];
   exp_t sb_q [$];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic iss, input logic [AW-1:0] ia,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic [AW-1:0] dbg);
      bus1.we         = we;
      bus1.waddr      = wa;
      bus1.wdata      = wd;
      bus1.issue_en   = iss;
      bus1.issue_addr = ia;
      bus1.raddr_a    = ra;
      bus1.raddr_b    = rb;
      bus1.debug_addr = dbg;
      bus1.clr_req    = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] fv(input int i);
      return 32'hC000_0000 | DW'(i * 32'h0001_0003);
   endfunction

   task automatic apply_vec(input int idx, input vec_t v);
      exp_t e;
      set_in(v.we, v.waddr, v.wdata, v.iss, v.iaddr, v.ra, v.rb, v.dbg);
      e.ra = v.e_ra; e.rb = v.e_rb; e.ba = v.e_ba; e.bb = v.e_bb; e.dbg = v.e_dbg;
      sb_q.push_back(e);
      #1;
      e = sb_q.pop_front();
      chk($sformatf("vec%0d rdata_a", idx), bus1.rdata_a, e.ra);
      chk($sformatf("vec%0d rdata_b", idx), bus1.rdata_b, e.rb);
      chk($sformatf("vec%0d busy_a", idx), DW'(bus1.busy_a), DW'(e.ba));
      chk($sformatf("vec%0d busy_b", idx), DW'(bus1.busy_b), DW'(e.bb));
      chk($sformatf("vec%0d debug_data", idx), bus1.debug_data, e.dbg);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      errors = 0;
      checks = 0;

      //          we wa  wdata          is ia  ra  rb  dbg   e_ra           e_rb           ba bb e_dbg
      vt[0]  = '{0, 0, 32'h0,         0, 0,  5, 31,  7, 32'h0,         32'h0,         0, 0, 32'h0};
      vt[1]  = '{1, 5, 32'hDEADBEEF,  0, 0,  1,  2,  5, 32'h0,         32'h0,         0, 0, 32'h0};
      vt[2]  = '{0, 0, 32'h0,         0, 0,  5,  0,  5, 32'hDEADBEEF,  32'h0,         0, 0, 32'hDEADBEEF};
      vt[3]  = '{1, 0, 32'h12345678,  0, 0,  0,  5,  0, 32'h0,         32'hDEADBEEF,  0, 0, 32'h0};
      vt[4]  = '{0, 0, 32'h0,         0, 0,  0,  0,  0, 32'h0,         32'h0,         0, 0, 32'h0};
      vt[5]  = '{1, 7, 32'hA5A5A5A5,  0, 0,  5,  7,  7, 32'hDEADBEEF,  32'hA5A5A5A5,  0, 0, 32'h0};
      vt[6]  = '{0, 0, 32'h0,         0, 0,  7,  5,  7, 32'hA5A5A5A5,  32'hDEADBEEF,  0, 0, 32'hA5A5A5A5};
      vt[7]  = '{0, 0, 32'h0,         1, 9,  9,  9,  9, 32'h0,         32'h0,         0, 0, 32'h0};
      vt[8]  = '{0, 0, 32'h0,         0, 0,  9,  9,  9, 32'h0,         32'h0,         1, 1, 32'h0};
      vt[9]  = '{1, 9, 32'h11112222,  1, 9,  9,  4,  9, 32'h11112222,  32'h0,         0, 0, 32'h0};
      vt[10] = '{0, 0, 32'h0,         0, 0,  9,  9,  9, 32'h11112222,  32'h11112222,  1, 1, 32'h11112222};
      vt[11] = '{1, 9, 32'h33334444,  0, 0,  3,  9,  9, 32'h0,         32'h33334444,  0, 0, 32'h11112222};
      vt[12] = '{0, 0, 32'h0,         0, 0,  9,  9,  9, 32'h33334444,  32'h33334444,  0, 0, 32'h33334444};
      vt[13] = '{0, 0, 32'h0,         1, 0,  0,  9,  0, 32'h0,         32'h33334444,  0, 0, 32'h0};
      vt[14] = '{0, 0, 32'h0,         0, 0,  0,  5,  9, 32'h0,         32'hDEADBEEF,  0, 0, 32'h33334444};

      set_in(0, 0, 0, 0, 0, 5, 9, 5);
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("reset rdata_a", bus1.rdata_a, 32'h0);
      chk("reset rdata_b", bus1.rdata_b, 32'h0);
      chk("reset busy_a", DW'(bus1.busy_a), 32'h0);
      chk("reset busy_b", DW'(bus1.busy_b), 32'h0);
      chk("reset debug_data", bus1.debug_data, 32'h0);
      chk("reset clr_busy", DW'(bus1.clr_busy), 32'h0);
      #9 rst_n = 1'b1;
      step();

      for (int i = 0; i < 15; i++) apply_vec(i, vt[i]);

      // Bypass on versus off with the same stimulus.
      set_in(1, 7, 32'h5A5A5A5A, 0, 0, 7, 7, 7);
      #1;
      chk("bypass1 rdata_b", bus1.rdata_b, 32'h5A5A5A5A);
      chk("bypass0 rdata_b", bus0.rdata_b, 32'hA5A5A5A5);
      step();
      set_in(0, 0, 0, 0, 0, 7, 0, 0);
      #1;
      chk("bypass0 stored r7", bus0.rdata_a, 32'h5A5A5A5A);
      step();

      // Sequential clear.
      for (int i = 1; i < 32; i++) begin
         set_in(1, AW'(i), fv(i), 0, 0, 0, 0, 0);
         step();
      end
      set_in(0, 0, 0, 1, 20, 31, 20, 17);
      step();
      set_in(0, 0, 0, 0, 0, 31, 20, 17);
      #1;
      chk("fill r31", bus1.rdata_a, fv(31));
      chk("fill busy r20", DW'(bus1.busy_b), 32'h1);
      chk("fill debug r17", bus1.debug_data, fv(17));
      bus1.clr_req = 1'b1;
      step();
      cnt = 0;
      for (int c = 0; c < 100 && bus1.clr_busy; c++) begin
         set_in(1, 1, 32'hFFFF_FFFF, 1, 1, 1, 31, 0);
         bus1.clr_req = (c == 5);
         #1;
         if (c == 0) chk("clear r31 not yet cleared", bus1.rdata_b, fv(31));
         if (c == 2) begin
            chk("clear r1 no bypass", bus1.rdata_a, 32'h0);
            chk("clear r1 busy", DW'(bus1.busy_a), 32'h0);
         end
         cnt++;
         step();
      end
      chk("clear cycle count", DW'(cnt), 32'd31);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("clear done clr_busy", DW'(bus1.clr_busy), 32'h0);
      begin
         int nz;
         nz = 0;
         for (int i = 0; i < 32; i++) begin
            set_in(0, 0, 0, 0, 0, AW'(i), AW'(i), AW'(i));
            #1;
            if (bus1.rdata_a !== 0 || bus1.busy_a !== 0 || bus1.debug_data !== 0) nz++;
         end
         chk("clear all zero count", DW'(nz), 32'h0);
      end
      set_in(0, 0, 0, 0, 0, 1, 20, 1);
      #1;
      chk("clear dropped write r1", bus1.debug_data, 32'h0);
      chk("clear busy r20", DW'(bus1.busy_b), 32'h0);
      step();

      // Reset in the middle of a clear.
      set_in(1, 10, 32'h1010_1010, 0, 0, 0, 0, 0); step();
      set_in(1, 31, 32'h3131_3131, 0, 0, 0, 0, 0); step();
      set_in(0, 0, 0, 1, 31, 0, 0, 0);
      bus1.clr_req = 1'b1;
      step();
      set_in(0, 0, 0, 0, 0, 3, 31, 10);
      repeat (9) step();
      #1;
      chk("midclear clr_busy", DW'(bus1.clr_busy), 32'h1);
      chk("midclear r31", bus1.rdata_b, 32'h3131_3131);
      chk("midclear r10", bus1.debug_data, 32'h1010_1010);
      rst_n = 1'b0;
      #1;
      chk("async rst clr_busy", DW'(bus1.clr_busy), 32'h0);
      chk("async rst r31", bus1.rdata_b, 32'h0);
      chk("async rst r10", bus1.debug_data, 32'h0);
      chk("async rst r3", bus1.rdata_a, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post rst clr_busy", DW'(bus1.clr_busy), 32'h0);
      set_in(1, 3, 32'h3333_0003, 0, 0, 3, 31, 3);
      step();
      set_in(0, 0, 0, 0, 0, 3, 31, 3);
      #1;
      chk("post rst write r3", bus1.rdata_a, 32'h3333_0003);
      chk("post rst debug r3", bus1.debug_data, 32'h3333_0003);
      chk("post rst busy r31", DW'(bus1.busy_b), 32'h0);
      chk("post rst idle", DW'(bus1.clr_busy), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
